sram_req_bridge: RTL and testbench

- Upstream request-side stage for the 32768x32 single-port byte-enabled SRAM wrapper.
- Converts a core/bus req/gnt/rvalid/rready interface into the SRAM's active-low CEN/GWEN/BEN controls and word address.
- Absorbs the SRAM's 1-cycle read latency and holds read data under consumer back-pressure.
- Sustains one access per cycle.

---
 rtl/sram_req_bridge.sv | 191 +++++++++++++++++++
 tb/tb_sram_req_bridge.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_bridge.sv
// rtl/sram_req_bridge.sv - req/gnt/rvalid front end for a 32768x32 single-port byte-enabled SRAM
//
// Purpose:
//   Turns a core-side request interface (req/gnt, rvalid/rready) into the
//   SRAM's active-low CEN/GWEN/BEN controls and word address. The SRAM's read
//   data arrives one cycle after the access. A hold register keeps that data
//   while the consumer stalls, so one access per cycle is sustained without
//   any request buffering.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous reset, active-low
//   req_i        request valid; must be held until gnt_o
//   gnt_o        request accepted this cycle (combinational)
//   addr_i       byte address; [ADDR_WIDTH+1:2] selects the SRAM word
//   we_i         1 = write, 0 = read
//   be_i         byte enables, active-high
//   wdata_i      write data
//   rvalid_o     response valid
//   rready_i     consumer accepts the response
//   rdata_o      read data; 0 for write and error responses
//   err_o        response error, qualified by rvalid_o
//   sram_cen_o   SRAM chip enable, active-low
//   sram_gwen_o  SRAM global write enable, active-low
//   sram_ben_o   SRAM byte enables, active-low
//   sram_a_o     SRAM word address
//   sram_d_o     SRAM write data
//   sram_q_i     SRAM read data, valid the cycle after the access
//
// Build option:
//   SRAM_BRIDGE_ADDR_CHECK_EN - when defined, requests whose upper address
//   bits fall outside the BASE_ADDR window are granted but do not touch the
//   SRAM and answer with err_o=1. When undefined the upper bits alias.

module sram_req_bridge #(
  parameter int          ADDR_WIDTH = 15,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h0010_0000
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [31:0]             addr_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,

  output logic                    rvalid_o,
  input  logic                    rready_i,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    err_o,

  output logic                    sram_cen_o,
  output logic                    sram_gwen_o,
  output logic [DATA_WIDTH/8-1:0] sram_ben_o,
  output logic [ADDR_WIDTH-1:0]   sram_a_o,
  output logic [DATA_WIDTH-1:0]   sram_d_o,
  input  logic [DATA_WIDTH-1:0]   sram_q_i
);

  localparam int NB = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,  // no response pending
    S_RESP_LIVE = 2'd1,  // response in its first cycle, data straight from the SRAM
    S_RESP_HELD = 2'd2   // response stalled, data from the hold register
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_we;
  logic                  r_oob;
  logic [DATA_WIDTH-1:0] r_hold;
  logic [DATA_WIDTH-1:0] w_hold_nxt;

  logic                  w_oob;
  logic                  w_gnt;
  logic                  w_resp_pending;

  // ---------------------------------------------------------------------------
  // Out-of-window detection
  // ---------------------------------------------------------------------------
`ifdef SRAM_BRIDGE_ADDR_CHECK_EN
  assign w_oob = (addr_i[31:ADDR_WIDTH+2] != BASE_ADDR[31:ADDR_WIDTH+2]);

  // Byte-offset bits never select anything.
  logic w_unused_addr;
  assign w_unused_addr = ^addr_i[1:0];
`else
  assign w_oob = 1'b0;

  // Upper bits alias onto the SRAM and the window base is irrelevant.
  logic w_unused_addr;
  assign w_unused_addr = ^{addr_i[31:ADDR_WIDTH+2], addr_i[1:0], BASE_ADDR};
`endif

  // ---------------------------------------------------------------------------
  // Grant
  // ---------------------------------------------------------------------------
  // A new request can be taken whenever the response slot is free or is being
  // drained this very cycle; that rready_i -> gnt_o path is what allows one
  // access per cycle while streaming.
  assign w_resp_pending = (r_state != S_IDLE);
  assign w_gnt          = rst_n & req_i & (~w_resp_pending | rready_i);
  assign gnt_o          = w_gnt;

  // ---------------------------------------------------------------------------
  // SRAM drive, straight from the accepted request
  // ---------------------------------------------------------------------------
  assign sram_cen_o  = ~(w_gnt & ~w_oob);
  assign sram_gwen_o = ~(w_gnt & we_i & ~w_oob);
  // Reads enable all lanes; BEN only has meaning while GWEN is active.
  assign sram_ben_o  = we_i ? ~be_i : {NB{1'b0}};
  assign sram_a_o    = addr_i[ADDR_WIDTH+1:2];
  assign sram_d_o    = wdata_i;

  // ---------------------------------------------------------------------------
  // Response FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_oob   <= 1'b0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
      // The response slot describes the most recently accepted request.
      if (w_gnt) begin
        r_we  <= we_i;
        r_oob <= w_oob;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    case (r_state)
      S_IDLE: begin
        if (w_gnt) begin
          w_state_nxt = S_RESP_LIVE;
        end
      end
      S_RESP_LIVE: begin
        if (rready_i) begin
          w_state_nxt = w_gnt ? S_RESP_LIVE : S_IDLE;
        end else begin
          // sram_q_i is only guaranteed for this one cycle, so freeze it now.
          w_state_nxt = S_RESP_HELD;
          w_hold_nxt  = (r_we | r_oob) ? '0 : sram_q_i;
        end
      end
      S_RESP_HELD: begin
        if (rready_i) begin
          w_state_nxt = w_gnt ? S_RESP_LIVE : S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Response outputs
  // ---------------------------------------------------------------------------
  assign rvalid_o = w_resp_pending;
  assign err_o    = w_resp_pending & r_oob;

  always_comb begin
    rdata_o = '0;
    case (r_state)
      S_RESP_LIVE: begin
        if (!r_we && !r_oob) begin
          rdata_o = sram_q_i;
        end
      end
      S_RESP_HELD: begin
        rdata_o = r_hold;
      end
      default: begin
        rdata_o = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_sram_req_bridge.sv
// tb/tb_sram_req_bridge.sv - self-checking bench for sram_req_bridge with SRAM and reference models

module tb_sram_req_bridge;

  localparam int          AW   = 15;
  localparam logic [31:0] BASE = 32'h0010_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_i;
  logic        gnt_o;
  logic [31:0] addr_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic        rvalid_o;
  logic        rready_i;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        sram_cen_o;
  logic        sram_gwen_o;
  logic [3:0]  sram_ben_o;
  logic [AW-1:0] sram_a_o;
  logic [31:0] sram_d_o;
  logic [31:0] sram_q_i;

  sram_req_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i), .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i),
    .rvalid_o(rvalid_o), .rready_i(rready_i), .rdata_o(rdata_o), .err_o(err_o),
    .sram_cen_o(sram_cen_o), .sram_gwen_o(sram_gwen_o), .sram_ben_o(sram_ben_o),
    .sram_a_o(sram_a_o), .sram_d_o(sram_d_o), .sram_q_i(sram_q_i)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM macro: active-low controls, 1-cycle read latency.
  logic [31:0] sram_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (!sram_cen_o) begin
      if (!sram_gwen_o) begin
        for (int l = 0; l < 4; l++)
          if (!sram_ben_o[l]) sram_mem[sram_a_o][8*l +: 8] <= sram_d_o[8*l +: 8];
      end else begin
        sram_q_i <= sram_mem[sram_a_o];
      end
    end
  end

  // Reference model: word store plus in-order queue of expected responses.
  typedef struct { logic [31:0] data; logic err; } resp_t;
  logic [31:0] ref_mem [0:(1<<AW)-1];
  resp_t       exp_q[$];

  int checks   = 0;
  int failures = 0;

  logic        obs_gnt, obs_rvalid, obs_err, obs_cen, obs_gwen;
  logic [31:0] obs_rdata, obs_d;
  logic [3:0]  obs_ben;
  logic [AW-1:0] obs_a;
  logic        had_pending;
  resp_t       front;

  function automatic logic oob_f(input logic [31:0] a);
`ifdef SRAM_BRIDGE_ADDR_CHECK_EN
    return a[31:AW+2] != BASE[31:AW+2];
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] b);
    logic [31:0] m;
    m = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
    return (old & ~m) | (d & m);
  endfunction

  // One clock: apply inputs, observe at the falling edge, advance model on observed handshakes.
  task automatic step(input logic rq, input logic w, input logic [31:0] a,
                      input logic [3:0] b, input logic [31:0] d, input logic rr);
    resp_t r;
    int    idx;
    req_i = rq; we_i = w; addr_i = a; be_i = b; wdata_i = d; rready_i = rr;
    @(negedge clk);
    had_pending = (exp_q.size() != 0);
    if (had_pending) front = exp_q[0];
    else begin front.data = 32'h0; front.err = 1'b0; end
    obs_gnt = gnt_o; obs_rvalid = rvalid_o; obs_rdata = rdata_o; obs_err = err_o;
    obs_cen = sram_cen_o; obs_gwen = sram_gwen_o; obs_ben = sram_ben_o; obs_a = sram_a_o; obs_d = sram_d_o;
    if (rst_n) begin
      if (obs_rvalid && rr && had_pending) void'(exp_q.pop_front());
      if (obs_gnt) begin
        idx    = int'(a[AW+1:2]);
        r.err  = oob_f(a);
        r.data = (w || r.err) ? 32'h0 : ref_mem[idx];
        exp_q.push_back(r);
        if (w && !r.err) ref_mem[idx] = merge(ref_mem[idx], d, b);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rr);
    step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, rr);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    step(1'b1, 1'b1, BASE, 4'hF, 32'h1234_5678, 1'b1);
    checks++; if (obs_gnt !== 1'b0) begin failures++; $display("FAIL reset_gnt got=%b exp=0", obs_gnt); end
    checks++; if (obs_cen !== 1'b1 || obs_gwen !== 1'b1) begin failures++; $display("FAIL reset_cen_gwen got=%b%b exp=11", obs_cen, obs_gwen); end
    step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
    checks++; if (obs_rvalid !== 1'b0 || obs_rdata !== 32'h0 || obs_err !== 1'b0) begin
      failures++; $display("FAIL reset_resp got rvalid=%b rdata=%h err=%b exp 0/0/0", obs_rvalid, obs_rdata, obs_err); end
    exp_q.delete();
    rst_n = 1'b1;
    idle(1'b1);
    checks++; if (obs_rvalid !== 1'b0) begin failures++; $display("FAIL reset_release_rvalid got=%b exp=0", obs_rvalid); end
  endtask

  task automatic test_read_after_write;
    step(1'b1, 1'b1, 32'h0010_0010, 4'hF, 32'hDEAD_BEEF, 1'b1);
    checks++; if (obs_gnt !== 1'b1 || obs_a !== 15'h4 || obs_cen !== 1'b0 || obs_gwen !== 1'b0) begin
      failures++; $display("FAIL raw_write_drive got gnt=%b a=%h cen=%b gwen=%b exp 1/4/0/0", obs_gnt, obs_a, obs_cen, obs_gwen); end
    step(1'b1, 1'b0, 32'h0010_0010, 4'h0, 32'h0, 1'b1);
    checks++; if (obs_gnt !== 1'b1 || obs_rvalid !== 1'b1 || obs_rdata !== 32'h0) begin
      failures++; $display("FAIL raw_write_resp got gnt=%b rvalid=%b rdata=%h exp 1/1/0", obs_gnt, obs_rvalid, obs_rdata); end
    checks++; if (obs_gwen !== 1'b1 || obs_cen !== 1'b0) begin
      failures++; $display("FAIL raw_read_drive got cen=%b gwen=%b exp 0/1", obs_cen, obs_gwen); end
    idle(1'b1);
    checks++; if (obs_rvalid !== 1'b1 || obs_rdata !== 32'hDEAD_BEEF || obs_err !== 1'b0) begin
      failures++; $display("FAIL raw_read_resp got rvalid=%b rdata=%h err=%b exp 1/deadbeef/0", obs_rvalid, obs_rdata, obs_err); end
    idle(1'b1);
    checks++; if (obs_rvalid !== 1'b0) begin failures++; $display("FAIL raw_idle_rvalid got=%b exp=0", obs_rvalid); end
  endtask

  task automatic test_byte_write;
    step(1'b1, 1'b1, 32'h0010_0020, 4'hF, 32'h1122_3344, 1'b1);
    step(1'b1, 1'b1, 32'h0010_0020, 4'b0101, 32'hAABB_CCDD, 1'b1);
    checks++; if (obs_ben !== 4'b1010 || obs_gwen !== 1'b0) begin
      failures++; $display("FAIL bytewr_drive got ben=%b gwen=%b exp 1010/0", obs_ben, obs_gwen); end
    // Empty byte mask: SRAM is still enabled but nothing may change.
    step(1'b1, 1'b1, 32'h0010_0020, 4'b0000, 32'hFFFF_FFFF, 1'b1);
    checks++; if (obs_cen !== 1'b0 || obs_gwen !== 1'b0 || obs_ben !== 4'b1111) begin
      failures++; $display("FAIL bytewr_be0_drive got cen=%b gwen=%b ben=%b exp 0/0/1111", obs_cen, obs_gwen, obs_ben); end
    step(1'b1, 1'b0, 32'h0010_0020, 4'h0, 32'h0, 1'b1);
    checks++; if (obs_rvalid !== 1'b1 || obs_rdata !== 32'h0) begin
      failures++; $display("FAIL bytewr_be0_resp got rvalid=%b rdata=%h exp 1/0", obs_rvalid, obs_rdata); end
    idle(1'b1);
    checks++; if (obs_rdata !== 32'h11BB_33DD) begin failures++; $display("FAIL bytewr_readback got=%h exp=11bb33dd", obs_rdata); end
  endtask

  task automatic test_back_pressure;
    step(1'b1, 1'b0, 32'h0010_0010, 4'h0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'h0010_0020, 4'h0, 32'h0, 1'b0);
      checks++; if (obs_rvalid !== 1'b1 || obs_rdata !== 32'hDEAD_BEEF || obs_gnt !== 1'b0) begin
        failures++; $display("FAIL bp_stall%0d got rvalid=%b rdata=%h gnt=%b exp 1/deadbeef/0", i, obs_rvalid, obs_rdata, obs_gnt); end
    end
    step(1'b1, 1'b0, 32'h0010_0020, 4'h0, 32'h0, 1'b1);
    checks++; if (obs_gnt !== 1'b1 || obs_rdata !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL bp_release got gnt=%b rdata=%h exp 1/deadbeef", obs_gnt, obs_rdata); end
    idle(1'b1);
    checks++; if (obs_rvalid !== 1'b1 || obs_rdata !== 32'h11BB_33DD) begin
      failures++; $display("FAIL bp_next got rvalid=%b rdata=%h exp 1/11bb33dd", obs_rvalid, obs_rdata); end
    idle(1'b1);
  endtask

  task automatic test_streaming;
    int n_resp;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, BASE + 32'h100 + 32'(4*i), 4'hF, $urandom, 1'b1);
    idle(1'b1);
    n_resp = 0;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) step(1'b1, 1'b0, BASE + 32'h100 + 32'(4*i), 4'h0, 32'h0, 1'b1);
      else       idle(1'b1);
      if (i < 8) begin
        checks++; if (obs_gnt !== 1'b1) begin failures++; $display("FAIL stream_gnt%0d got=%b exp=1", i, obs_gnt); end
      end
      if (i > 0) begin
        checks++; if (obs_rvalid !== 1'b1 || obs_rdata !== front.data) begin
          failures++; $display("FAIL stream_resp%0d got rvalid=%b rdata=%h exp 1/%h", i, obs_rvalid, obs_rdata, front.data); end
        if (obs_rvalid) n_resp++;
      end
    end
    checks++; if (n_resp != 8) begin failures++; $display("FAIL stream_count got=%0d exp=8", n_resp); end
    idle(1'b1);
  endtask

  task automatic test_reset_mid_response;
    step(1'b1, 1'b0, 32'h0010_0010, 4'h0, 32'h0, 1'b0);
    idle(1'b0);
    rst_n = 1'b0;
    step(1'b1, 1'b0, 32'h0010_0020, 4'h0, 32'h0, 1'b0);
    checks++; if (obs_gnt !== 1'b0 || obs_cen !== 1'b1) begin
      failures++; $display("FAIL rstmid_drive got gnt=%b cen=%b exp 0/1", obs_gnt, obs_cen); end
    exp_q.delete();
    rst_n = 1'b1;
    idle(1'b1);
    checks++; if (obs_rvalid !== 1'b0 || obs_rdata !== 32'h0 || obs_cen !== 1'b1) begin
      failures++; $display("FAIL rstmid_after got rvalid=%b rdata=%h cen=%b exp 0/0/1", obs_rvalid, obs_rdata, obs_cen); end
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      checks++; if (obs_rvalid !== 1'b0) begin failures++; $display("FAIL rstmid_spurious%0d got=%b exp=0", i, obs_rvalid); end
    end
  endtask

  task automatic test_addr_check;
    logic oob;
    oob = oob_f(32'h0020_0000);
    step(1'b1, 1'b0, 32'h0020_0000, 4'h0, 32'h0, 1'b1);
    checks++; if (obs_gnt !== 1'b1 || obs_cen !== oob || obs_a !== 15'h0) begin
      failures++; $display("FAIL oob_drive got gnt=%b cen=%b a=%h exp 1/%b/0", obs_gnt, obs_cen, obs_a, oob); end
    idle(1'b1);
    checks++; if (obs_rvalid !== 1'b1 || obs_err !== front.err || obs_rdata !== front.data) begin
      failures++; $display("FAIL oob_resp got rvalid=%b err=%b rdata=%h exp 1/%b/%h", obs_rvalid, obs_err, obs_rdata, front.err, front.data); end
    idle(1'b1);
  endtask

  task automatic test_random;
    logic        rq, w, rr, eg, oob;
    logic [31:0] a;
    logic [3:0]  b;
    for (int i = 0; i < 400; i++) begin
      rq  = ($urandom_range(0, 9) < 7);
      w   = $urandom_range(0, 1);
      rr  = ($urandom_range(0, 9) < 6);
      a   = BASE + 32'(4 * $urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) a[31:AW+2] = 15'($urandom);
      b   = 4'($urandom);
      oob = oob_f(a);
      step(rq, w, a, b, $urandom, rr);
      eg = rq & (~had_pending | rr);
      checks++; if (obs_gnt !== eg) begin failures++; $display("FAIL rnd_gnt%0d got=%b exp=%b", i, obs_gnt, eg); end
      checks++; if (obs_cen !== ~(eg & ~oob) || obs_gwen !== ~(eg & w & ~oob)) begin
        failures++; $display("FAIL rnd_ctl%0d got cen=%b gwen=%b exp %b/%b", i, obs_cen, obs_gwen, ~(eg & ~oob), ~(eg & w & ~oob)); end
      checks++; if (obs_rvalid !== had_pending) begin failures++; $display("FAIL rnd_rvalid%0d got=%b exp=%b", i, obs_rvalid, had_pending); end
      if (had_pending) begin
        checks++; if (obs_rdata !== front.data || obs_err !== front.err) begin
          failures++; $display("FAIL rnd_resp%0d got rdata=%h err=%b exp %h/%b", i, obs_rdata, obs_err, front.data, front.err); end
      end
    end
    for (int i = 0; i < 4; i++) idle(1'b1);
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rnd_drain got=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      sram_mem[i] = 32'h0;
      ref_mem[i]  = 32'h0;
    end
    sram_q_i = 32'h0;
    rst_n = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = 32'h0; be_i = 4'h0; wdata_i = 32'h0; rready_i = 1'b1;
    @(posedge clk); #1;
    test_reset;
    test_read_after_write;
    test_byte_write;
    test_back_pressure;
    test_streaming;
    test_reset_mid_response;
    test_addr_check;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
